// File: rtl/instr_fetch_unit_pkg.sv
// Shared widths, PC step and entry layout for the instruction fetch unit.
package instr_fetch_unit_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned ADDR_W  = 32;

   localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;
   localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Synchronous FIFO of fetched words; flush takes priority over push and pop.
module instr_fetch_unit_fetch_fifo
   import instr_fetch_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = INSTR_W + ADDR_W,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   // Storage is reset too so the head output is never X after reset.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_comb begin
      rdata = mem[rd_ptr];
      empty = (count == '0);
      full  = (count == CNT_W'(DEPTH));
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC, credit-limited request issue to instruction memory, response
// buffering and redirect squashing for the single-cycle datapath.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int unsigned      DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic               clk,
   input  logic               Reset,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] Instr,
   output logic [ADDR_W-1:0]  InstrPC,
   output logic               InstrValid,
   input  logic               InstrReady,
   input  logic               Redirect,
   input  logic [ADDR_W-1:0]  RedirectPC
);

   localparam int unsigned OUT_W = $clog2(DEPTH + 1);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] resp_pc;
   logic [OUT_W-1:0]  outstanding;
   logic [OUT_W-1:0]  outstanding_next;
   logic [OUT_W-1:0]  drop_cnt;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty;
   logic              fifo_full;
   logic              credit_ok;
   logic              accept;
   logic              resp;
   logic              push;
   logic              pop;
   fetch_entry_t      push_entry;
   fetch_entry_t      head_entry;

   // Buffered plus in-flight words never exceed DEPTH, so a push always has room.
   always_comb begin
      credit_ok        = (32'(fifo_count) + 32'(outstanding)) < DEPTH;
      imem_req         = !Reset && !Redirect && credit_ok;
      imem_addr        = fetch_pc;
      accept           = imem_req && imem_gnt;
      resp             = imem_rvalid && (outstanding != '0);
      push             = resp && (drop_cnt == '0) && !Redirect;
      pop              = !fifo_empty && InstrReady && !Redirect;
      outstanding_next = outstanding + OUT_W'(accept) - OUT_W'(resp);
      push_entry.instr = imem_rdata;
      push_entry.pc    = resp_pc;
      Instr            = head_entry.instr;
      InstrPC          = head_entry.pc;
      InstrValid       = !fifo_empty;
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding_next;
         if (Redirect) begin
            fetch_pc <= RedirectPC;
            resp_pc  <= RedirectPC;
            // Everything still in flight after this cycle belongs to the old path.
            drop_cnt <= outstanding_next;
         end else begin
            if (accept) begin
               fetch_pc <= fetch_pc + PC_STEP;
            end
            if (push) begin
               resp_pc <= resp_pc + PC_STEP;
            end
            if (resp && (drop_cnt != '0)) begin
               drop_cnt <= drop_cnt - OUT_W'(1);
            end
         end
      end
   end

   instr_fetch_unit_fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (INSTR_W + ADDR_W)
   ) u_fetch_fifo (
      .clk   (clk),
      .Reset (Reset),
      .flush (Redirect),
      .push  (push),
      .pop   (pop),
      .wdata (push_entry),
      .rdata (head_entry),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   a_rvalid_expected: assert property (@(posedge clk) disable iff (Reset)
      imem_rvalid |-> (outstanding != '0));

   a_no_overflow: assert property (@(posedge clk) disable iff (Reset)
      (push && !pop) |-> !fifo_full);

   a_drop_bounded: assert property (@(posedge clk) disable iff (Reset)
      drop_cnt <= outstanding);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with an in-order variable-latency memory model.
module tb_instr_fetch_unit;

   logic        clk;
   logic        Reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] Instr;
   logic [31:0] InstrPC;
   logic        InstrValid;
   logic        InstrReady;
   logic        Redirect;
   logic [31:0] RedirectPC;

   instr_fetch_unit #(
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .Reset       (Reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .Instr       (Instr),
      .InstrPC     (InstrPC),
      .InstrValid  (InstrValid),
      .InstrReady  (InstrReady),
      .Redirect    (Redirect),
      .RedirectPC  (RedirectPC)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] data;
   } mem_rsp_t;

   mem_rsp_t    mem_q[$];
   logic [31:0] exp_q[$];
   int          vectors;
   int          miscompares;
   int          cyc;
   int          lat;
   int          last_due;
   logic        gnt_en;
   logic [31:0] model_pc;
   int          accepts;
   int          pops;
   logic [31:0] first_pc;
   logic [31:0] last_pc;
   logic        obs_valid;

   function automatic logic [31:0] word_at(input logic [31:0] pc);
      return pc ^ 32'hA5C3_5A3C;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock: entered and left at a falling edge.
   task automatic step();
      mem_rsp_t    r;
      logic [31:0] e;
      logic        consume;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         r           = mem_q.pop_front();
         imem_rvalid = 1'b1;
         imem_rdata  = r.data;
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 32'h0;
      end
      imem_gnt = gnt_en;
      #1;
      obs_valid = InstrValid;
      if (Redirect) check("req_on_redirect", {31'h0, imem_req}, 32'h0);
      if (imem_req) check("imem_addr", imem_addr, model_pc);
      consume = InstrValid && InstrReady && !Redirect;
      if (consume) begin
         if (exp_q.size() == 0) begin
            check("spurious_valid", {31'h0, InstrValid}, 32'h0);
         end else begin
            e = exp_q.pop_front();
            check("instr_pc", InstrPC, e);
            check("instr", Instr, word_at(e));
         end
         if (pops == 0) first_pc = InstrPC;
         last_pc = InstrPC;
         pops++;
      end
      if (Redirect) begin
         exp_q.delete();
         model_pc = RedirectPC;
      end
      if (imem_req && imem_gnt) begin
         r.due    = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
         r.data   = word_at(imem_addr);
         last_due = r.due;
         mem_q.push_back(r);
         exp_q.push_back(model_pc);
         model_pc = model_pc + 32'd4;
         accepts++;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic clear_models();
      mem_q.delete();
      exp_q.delete();
      model_pc    = 32'h0;
      cyc         = 0;
      last_due    = -1;
      accepts     = 0;
      pops        = 0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
   endtask

   task automatic apply_reset();
      Reset = 1'b1;
      clear_models();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      Reset = 1'b0;
   endtask

   int gaps;
   int first_valid;

   initial begin
      vectors     = 0;
      miscompares = 0;
      Reset       = 1'b1;
      imem_gnt    = 1'b0;
      Redirect    = 1'b0;
      RedirectPC  = 32'h0;
      InstrReady  = 1'b0;
      gnt_en      = 1'b1;
      lat         = 1;
      clear_models();
      @(negedge clk);
      #1;
      check("rst_req", {31'h0, imem_req}, 32'h0);
      check("rst_valid", {31'h0, InstrValid}, 32'h0);
      check("rst_instr", Instr, 32'h0);
      check("rst_instr_pc", InstrPC, 32'h0);
      @(negedge clk);
      Reset = 1'b0;

      // Zero-wait streaming: first word visible two cycles after first request, then no gaps.
      InstrReady  = 1'b1;
      gaps        = 0;
      first_valid = -1;
      for (int i = 0; i < 24; i++) begin
         step();
         if (obs_valid && first_valid < 0) first_valid = i;
         if (i >= 2 && !obs_valid) gaps++;
      end
      check("fill_latency", first_valid, 32'd2);
      check("stream_gaps", gaps, 32'd0);
      check("stream_first_pc", first_pc, 32'h0);

      // Consumer stalled: credit caps requests at DEPTH, then drains in order.
      apply_reset();
      InstrReady = 1'b0;
      for (int i = 0; i < 10; i++) step();
      check("full_accepts", accepts, 32'd4);
      check("full_req_low", {31'h0, imem_req}, 32'h0);
      InstrReady = 1'b1;
      for (int i = 0; i < 10; i++) step();
      check("drain_first_pc", first_pc, 32'h0);
      check("drain_resume", {31'h0, accepts > 4}, 32'h1);

      // Grant withheld at 0x10: address holds, nothing extra appears.
      apply_reset();
      InstrReady = 1'b1;
      for (int i = 0; i < 4; i++) step();
      gnt_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("stall_req", {31'h0, imem_req}, 32'h1);
         check("stall_addr", imem_addr, 32'h10);
         step();
      end
      check("stall_pops", pops, 32'd4);
      gnt_en = 1'b1;
      for (int i = 0; i < 3; i++) step();
      check("stall_resume_pops", pops, 32'd5);
      check("stall_resume_pc", last_pc, 32'h10);

      // Redirect with two requests in flight at latency 3.
      apply_reset();
      lat        = 3;
      InstrReady = 1'b1;
      step();
      step();
      Redirect   = 1'b1;
      RedirectPC = 32'h200;
      step();
      Redirect   = 1'b0;
      check("redir_drop_cnt", {29'h0, dut.drop_cnt}, 32'd2);
      pops = 0;
      for (int i = 0; i < 14; i++) step();
      check("redir_first_pc", first_pc, 32'h200);
      check("redir_pops", {31'h0, pops > 2}, 32'h1);

      // Redirect colliding with rvalid and a pop while three words are buffered.
      apply_reset();
      lat        = 1;
      InstrReady = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check("pre_redir_valid", {31'h0, InstrValid}, 32'h1);
      InstrReady = 1'b1;
      Redirect   = 1'b1;
      RedirectPC = 32'h300;
      step();
      Redirect   = 1'b0;
      check("flush_valid", {31'h0, InstrValid}, 32'h0);
      check("flush_drop_cnt", {29'h0, dut.drop_cnt}, 32'd0);
      check("flush_outstanding", {29'h0, dut.outstanding}, 32'd0);
      pops = 0;
      for (int i = 0; i < 8; i++) step();
      check("flush_first_pc", first_pc, 32'h300);

      // Asynchronous reset mid-stream with three buffered words.
      apply_reset();
      InstrReady = 1'b0;
      for (int i = 0; i < 3; i++) step();
      gnt_en = 1'b0;
      step();
      step();
      check("pre_rst_valid", {31'h0, InstrValid}, 32'h1);
      check("pre_rst_req", {31'h0, imem_req}, 32'h1);
      #2;
      Reset = 1'b1;
      #1;
      check("async_rst_valid", {31'h0, InstrValid}, 32'h0);
      check("async_rst_req", {31'h0, imem_req}, 32'h0);
      check("async_rst_instr", Instr, 32'h0);
      clear_models();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      Reset      = 1'b0;
      gnt_en     = 1'b1;
      InstrReady = 1'b1;
      check("restart_addr", imem_addr, 32'h0);
      for (int i = 0; i < 8; i++) step();
      check("restart_first_pc", first_pc, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running want finished");
      $fatal(1);
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the single-cycle datapath. Owns the fetch PC and issues in-order word requests to instruction memory, which may stall or respond with variable latency.
- Buffers returned words with their PCs in a small FIFO and presents them to the datapath as Instr/InstrPC with a valid/ready handshake.
- A branch redirect from the datapath flushes the buffer and squashes in-flight responses.

Parameters:
- DEPTH, 4, FIFO entries; also the cap on buffered plus outstanding requests. Power of two, at least 2.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.

Ports:
- clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  word address of request (= fetch_pc)
- imem_gnt  in  1  request accepted this cycle when imem_req & imem_gnt
- imem_rvalid  in  1  response valid; responses return in request order
- imem_rdata  in  32  response instruction word
- Instr  out  32  FIFO head instruction
- InstrPC  out  32  address of Instr
- InstrValid  out  1  FIFO non-empty
- InstrReady  in  1  datapath consumes head when InstrValid & InstrReady
- Redirect  in  1  branch taken; one-cycle pulse
- RedirectPC  in  32  new fetch target; word-aligned

Behaviour:
- Reset (async, any time, including mid-transaction):
  - fetch_pc and resp_pc = RESET_PC; FIFO empty; outstanding = 0; drop_cnt = 0.
  - Outputs: imem_req = 0, InstrValid = 0, Instr = 0, InstrPC = 0.
  - Memory is expected to abandon in-flight responses on Reset.
- Credit rule: imem_req = !Reset & !Redirect & (fifo_count + outstanding < DEPTH). This guarantees the FIFO never overflows.
- Request acceptance (req & gnt): fetch_pc += 4, wrapping modulo 2^32; outstanding += 1. imem_addr holds stable while req is high and gnt is low.
- Response (rvalid):
  - outstanding -= 1.
  - If drop_cnt > 0: drop_cnt -= 1 and the word is discarded.
  - Otherwise push {imem_rdata, resp_pc}, then resp_pc += 4.
  - rvalid with outstanding == 0 is a protocol violation: ignored, and flagged by a simulation assertion.
- Latency: a response accepted in cycle N is visible as InstrValid/Instr in cycle N+1. There is no combinational bypass.
- Pop: on InstrValid & InstrReady the head advances. Simultaneous push and pop leaves the count unchanged. Push when full cannot occur (assertion).
- Redirect (same cycle):
  - FIFO cleared; fetch_pc and resp_pc = RedirectPC.
  - drop_cnt = outstanding + (req&gnt ? 1 : 0) - (rvalid ? 1 : 0); the response arriving in the redirect cycle is itself discarded.
  - imem_req is forced to 0 that cycle, so the accepted term is 0 by construction.
  - Redirect overrides any pop or push that cycle.
  - The first new request issues in cycle N+1 at RedirectPC.
- Back-to-back redirects: each one recomputes drop_cnt from the current outstanding count; the last one wins.
- Counter widths: outstanding and drop_cnt use $clog2(DEPTH+1) bits. fifo_count uses $clog2(DEPTH)+1 bits. drop_cnt ≤ outstanding always holds (assertion).
- Output data when InstrValid = 0 is don't-care but driven from registers, never X after reset.

Decomposition:
- Shared package holds:
  - INSTR_W = 32, ADDR_W = 32
  - PC_STEP = 32'd4
  - default RESET_PC
- One natural sub-module: fetch_fifo.
  - Synchronous FIFO, width INSTR_W+ADDR_W, depth DEPTH, with push, pop, and a flush input that has priority.
  - Outputs: count, empty, full.
- The top level holds the PC registers, the outstanding/drop counters and the credit logic.

Test Plan:
- Zero-wait memory (gnt=1, rvalid one cycle after accept), InstrReady=1 → Instr/InstrPC stream 0x0, 0x4, 0x8, … with one word per cycle after initial fill, and no gaps.
- InstrReady=0 with DEPTH=4 → exactly 4 requests accepted; imem_req stays 0 while full. Raising InstrReady then drains the words in order at 0x0–0xC, and requests resume.
- gnt held low 5 cycles at fetch_pc=0x10 → imem_addr stays 0x10 and nothing is pushed. On grant, 0x10 returns next.
- Redirect to 0x200 with 2 outstanding (response latency 3) → the next 2 rvalid words are discarded; the first InstrValid carries InstrPC=0x200.
- Redirect in the same cycle as rvalid, plus a pop with 3 entries buffered → FIFO empty next cycle, the rvalid word is discarded, and drop_cnt equals the remaining outstanding.
- Reset asserted mid-stream with 3 buffered entries → InstrValid and imem_req drop to 0 immediately (async). After release, fetch restarts at RESET_PC=0x0.
